// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: bus-side bundle for the UART receiver.
// The slave modport is the receiver itself; the master modport is whoever
// drives the serial line and services the receive FIFO.
`timescale 1ns/1ps
interface uart_rx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
);
    logic                               rx;
    logic                               stb;
    logic                               err_clr;
    logic [DATA_BITS-1:0]               data;
    logic                               valid;
    logic [$clog2(FIFO_DEPTH+1)-1:0]    level;
    logic                               frame_err;
    logic                               parity_err;
    logic                               overrun;
    logic                               irq;

    modport slave (
        input  rx, stb, err_clr,
        output data, valid, level, frame_err, parity_err, overrun, irq
    );

    modport master (
        output rx, stb, err_clr,
        input  data, valid, level, frame_err, parity_err, overrun, irq
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver with start-bit glitch rejection, optional
// parity, stop-bit check, sticky error flags and a show-ahead receive FIFO.
// Optional feature macro: UART_RX_SYNC_EN adds a two-flop synchroniser
// (reset to idle-high) in front of the rx pin; without it rx must already
// be synchronous to clk.
`timescale 1ns/1ps
module uart_rx_fifo #(
    parameter int TICKS_PER_BAUD = 434,
    parameter int DATA_BITS      = 8,
    parameter int PARITY         = 0,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_fifo_if.slave  bus
);
    localparam int CW = $clog2(TICKS_PER_BAUD);
    localparam logic [CW-1:0] HALF = CW'(TICKS_PER_BAUD / 2);
    localparam logic [CW-1:0] LAST = CW'(TICKS_PER_BAUD - 1);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic rx_s;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;

    // Two-flop synchroniser; resets to the idle (high) line level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], bus.rx};
    end
    assign rx_s = sync_q[1];
`else
    assign rx_s = bus.rx;
`endif

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 mid, par_bad, push_req, frame_set, parity_set;

    assign mid = (cnt_q == HALF);

    // XOR over data and parity bit: odd parity wants 1, even parity wants 0
    assign par_bad = (PARITY == 1) ? ~(^shift_q ^ par_q) :
                     (PARITY == 2) ?  (^shift_q ^ par_q) : 1'b0;

    // Receiver state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
        end
    end

    // Frame sequencing: every bit is sampled at the same mid-bit count,
    // the bit counter free-runs and wraps at each bit boundary
    always_comb begin
        state_d    = state_q;
        cnt_d      = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        bit_d      = bit_q;
        shift_d    = shift_q;
        par_d      = par_q;
        push_req   = 1'b0;
        frame_set  = 1'b0;
        parity_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (!rx_s) state_d = S_START;
            end
            S_START: begin
                if (mid) begin
                    // A start bit that is high again at mid-bit was a glitch
                    state_d = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (mid) begin
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + BW'(1);
                    if (bit_q == LAST_BIT) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (mid) begin
                    par_d   = rx_s;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (mid) begin
                    // Back to IDLE at mid-stop so the next start bit is seen early
                    state_d    = S_IDLE;
                    frame_set  = ~rx_s;
                    parity_set = par_bad;
                    push_req   = rx_s & ~par_bad;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]          wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0]        level_q, level_d;
    logic                 valid_q, valid_d, irq_q, irq_d;
    logic                 frame_q, frame_d, parity_q, parity_d, overrun_q, overrun_d;
    logic                 full, pop, push;

    assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop  = bus.stb & valid_q;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands
    assign push = push_req & (~full | pop);

    // FIFO pointers, occupancy and sticky flags (set wins over err_clr)
    always_comb begin
        wr_d      = push ? wr_q + (AW+1)'(1) : wr_q;
        rd_d      = pop  ? rd_q + (AW+1)'(1) : rd_q;
        level_d   = LW'(wr_d - rd_d);
        valid_d   = (wr_d != rd_d);
        frame_d   = (frame_q   & ~bus.err_clr) | frame_set;
        parity_d  = (parity_q  & ~bus.err_clr) | parity_set;
        overrun_d = (overrun_q & ~bus.err_clr) | (push_req & full & ~pop);
        irq_d     = valid_d | frame_d | parity_d | overrun_d;
    end

    // Status registers; all outputs come from here or from the FIFO storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q      <= '0;
            rd_q      <= '0;
            level_q   <= '0;
            valid_q   <= 1'b0;
            frame_q   <= 1'b0;
            parity_q  <= 1'b0;
            overrun_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            level_q   <= level_d;
            valid_q   <= valid_d;
            frame_q   <= frame_d;
            parity_q  <= parity_d;
            overrun_q <= overrun_d;
            irq_q     <= irq_d;
        end
    end

    // FIFO storage, cleared on reset so the head reads 0 while empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_q[AW-1:0]] <= shift_q;
        end
    end

    assign bus.data       = mem_q[rd_q[AW-1:0]];
    assign bus.valid      = valid_q;
    assign bus.level      = level_q;
    assign bus.frame_err  = frame_q;
    assign bus.parity_err = parity_q;
    assign bus.overrun    = overrun_q;
    assign bus.irq        = irq_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench for uart_rx_fifo (no-parity and even-parity
// instances, 16 clocks per bit, 4-entry FIFO).
`timescale 1ns/1ps
module tb_uart_rx_fifo;
    localparam int TPB = 16;

    logic clk;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if0 ();
    uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if2 ();

    uart_rx_fifo #(.TICKS_PER_BAUD(TPB), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4))
        dut0 (.clk(clk), .rst(rst), .bus(if0));
    uart_rx_fifo #(.TICKS_PER_BAUD(TPB), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(4))
        dut2 (.clk(clk), .rst(rst), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Every stimulus task starts and ends 1 time unit after a rising edge
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_rx(input bit sel, input logic b);
        if (sel) if2.rx = b;
        else     if0.rx = b;
    endtask

    task automatic send_bit(input bit sel, input logic b, input int n);
        set_rx(sel, b);
        wait_cyc(n);
    endtask

    // start, nb bits of d LSB first (parity rides in d[8]), stop
    task automatic send_frame(input bit sel, input logic [8:0] d, input int nb, input logic stop);
        send_bit(sel, 1'b0, TPB);
        for (int i = 0; i < nb; i++) send_bit(sel, d[i], TPB);
        send_bit(sel, stop, TPB);
        set_rx(sel, 1'b1);
    endtask

    task automatic pop(input bit sel);
        if (sel) if2.stb = 1'b1; else if0.stb = 1'b1;
        wait_cyc(1);
        if2.stb = 1'b0;
        if0.stb = 1'b0;
    endtask

    task automatic clr(input bit sel);
        if (sel) if2.err_clr = 1'b1; else if0.err_clr = 1'b1;
        wait_cyc(1);
        if2.err_clr = 1'b0;
        if0.err_clr = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] w;
        rst = 1'b1;
        if0.rx = 1'b1; if0.stb = 1'b0; if0.err_clr = 1'b0;
        if2.rx = 1'b1; if2.stb = 1'b0; if2.err_clr = 1'b0;
        wait_cyc(3);

        // reset state
        check_eq("rst_valid",   if0.valid, 0);
        check_eq("rst_level",   if0.level, 0);
        check_eq("rst_irq",     if0.irq, 0);
        check_eq("rst_data",    if0.data, 0);
        check_eq("rst_frame",   if0.frame_err, 0);
        check_eq("rst_parity",  if0.parity_err, 0);
        check_eq("rst_overrun", if0.overrun, 0);
        rst = 1'b0;
        wait_cyc(4);

        // single word then pop
        send_frame(0, 9'h0A5, 8, 1'b1);
        check_eq("a5_valid", if0.valid, 1);
        check_eq("a5_level", if0.level, 1);
        check_eq("a5_data",  if0.data, 8'hA5);
        check_eq("a5_irq",   if0.irq, 1);
        pop(0);
        check_eq("pop_valid", if0.valid, 0);
        check_eq("pop_level", if0.level, 0);
        check_eq("pop_irq",   if0.irq, 0);

        // short low glitch is rejected, next frame is fine
        send_bit(0, 1'b0, 4);
        send_bit(0, 1'b1, 30);
        check_eq("glitch_level",   if0.level, 0);
        check_eq("glitch_irq",     if0.irq, 0);
        check_eq("glitch_frame",   if0.frame_err, 0);
        check_eq("glitch_parity",  if0.parity_err, 0);
        check_eq("glitch_overrun", if0.overrun, 0);
        send_frame(0, 9'h03C, 8, 1'b1);
        check_eq("3c_data",  if0.data, 8'h3C);
        check_eq("3c_level", if0.level, 1);
        pop(0);
        check_eq("3c_pop_level", if0.level, 0);

        // bad stop bit
        send_frame(0, 9'h03C, 8, 1'b0);
        wait_cyc(TPB);
        check_eq("ferr_flag",  if0.frame_err, 1);
        check_eq("ferr_level", if0.level, 0);
        check_eq("ferr_valid", if0.valid, 0);
        check_eq("ferr_irq",   if0.irq, 1);
        clr(0);
        check_eq("ferr_clr", if0.frame_err, 0);
        check_eq("ferr_clr_irq", if0.irq, 0);

        // five words into a four-entry FIFO
        for (int v = 1; v <= 5; v++) send_frame(0, 9'(v), 8, 1'b1);
        wait_cyc(4);
        check_eq("ovr_level", if0.level, 4);
        check_eq("ovr_flag",  if0.overrun, 1);
        for (int k = 1; k <= 4; k++) begin
            check_eq($sformatf("ovr_data%0d", k), if0.data, k);
            pop(0);
        end
        check_eq("ovr_empty", if0.valid, 0);
        clr(0);
        check_eq("ovr_clr", if0.overrun, 0);

        // even parity: 0x07 has three ones, so parity bit must be 1
        send_frame(1, {1'b0, 8'h07}, 9, 1'b1);
        check_eq("par_flag",  if2.parity_err, 1);
        check_eq("par_level", if2.level, 0);
        check_eq("par_irq",   if2.irq, 1);
        check_eq("par_frame", if2.frame_err, 0);
        send_frame(1, {1'b1, 8'h07}, 9, 1'b1);
        check_eq("par_ok_data",   if2.data, 8'h07);
        check_eq("par_ok_level",  if2.level, 1);
        check_eq("par_sticky",    if2.parity_err, 1);
        check_eq("par_noverrun",  if2.overrun, 0);

        // reset during data bit 3 with one word stored
        send_frame(0, 9'h011, 8, 1'b1);
        check_eq("pre_rst_level", if0.level, 1);
        w = 9'h05A;
        send_bit(0, 1'b0, TPB);
        for (int i = 0; i < 3; i++) send_bit(0, w[i], TPB);
        send_bit(0, w[3], TPB / 2);
        rst = 1'b1;
        #1;
        check_eq("mrst_valid",   if0.valid, 0);
        check_eq("mrst_level",   if0.level, 0);
        check_eq("mrst_data",    if0.data, 0);
        check_eq("mrst_irq",     if0.irq, 0);
        check_eq("mrst_frame",   if0.frame_err, 0);
        check_eq("mrst_overrun", if0.overrun, 0);
        check_eq("mrst_p_level", if2.level, 0);
        set_rx(0, 1'b1);
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(20);
        send_frame(0, 9'h05A, 8, 1'b1);
        check_eq("post_rst_data",  if0.data, 8'h5A);
        check_eq("post_rst_level", if0.level, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
